// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Contents:
//   state_t   - divider FSM state (IDLE, CALC, DONE), 2-bit encoding
//   DIV_N     - default operand width
//   cnt_width - iteration counter width needed to hold the value n
//   CNT_W     - counter width for the default operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_N = 4;

    // The counter is loaded with n and counts down to 0, so it must hold n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between the ALU and the sequential divider.
// Signals:
//   start              - begin a division (master -> slave)
//   dividend, divisor  - N-bit unsigned operands, sampled with start (master -> slave)
//   busy               - operation in progress (slave -> master)
//   done               - one-cycle completion pulse (slave -> master)
//   quotient, remainder - N-bit results (slave -> master)
//   div_zero           - last operation had a zero divisor (slave -> master)
interface div_seq_ctrl_if #(
    parameter int N = 4
);

    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/div_sub_step.sv
// Combinational W-bit subtractor used for one restoring-division step.
// Ports:
//   a, b   - W-bit unsigned operands
//   diff   - a - b modulo 2^W
//   borrow - 1 when a < b
// a - b is formed as a + ~b + 1; the carry out is 1 exactly when no borrow occurs.
module div_sub_step #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] sum_s;

    // Complement-and-add with carry-in of one, widened to keep the carry out.
    assign sum_s  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    assign diff   = sum_s[W-1:0];
    assign borrow = ~sum_s[W];

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential unsigned restoring divider: one shared subtract step reused for N
// iterations under a small FSM. Results appear N+1 cycles after an accepted
// start (1 cycle for a zero divisor) together with a one-cycle done pulse.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset, highest priority
//   bus - div_seq_ctrl_if slave: start/dividend/divisor in,
//         busy/done/quotient/remainder/div_zero out (all registered)
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst,
    div_seq_ctrl_if.slave  bus
);

    localparam int CW = cnt_width(N);

    state_t        state_r;
    logic [N:0]    r_r;        // partial remainder
    logic [N-1:0]  q_r;        // dividend bits shifting out, quotient bits shifting in
    logic [N-1:0]  d_r;        // latched divisor
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic          done_r;
    logic [N-1:0]  quot_r;
    logic [N-1:0]  rem_r;
    logic          dz_r;

    logic [N:0]    shift_s;
    logic [N:0]    dext_s;
    logic [N:0]    diff_s;
    logic          borrow_s;
    logic [N:0]    next_r_s;
    logic [N-1:0]  next_q_s;
    logic          unused_r_msb_s;

    // The stored remainder is always below the divisor, so its top bit is zero
    // between steps and only the low bits feed the next shift.
    assign unused_r_msb_s = r_r[N];

    assign shift_s = {r_r[N-1:0], q_r[N-1]};
    assign dext_s  = {1'b0, d_r};

    div_sub_step #(
        .W (N + 1)
    ) u_sub (
        .a      (shift_s),
        .b      (dext_s),
        .diff   (diff_s),
        .borrow (borrow_s)
    );

    // Restoring step: keep the trial difference only when it did not borrow.
    always_comb begin
        next_r_s = shift_s;
        if (borrow_s) begin
            next_r_s = shift_s;
        end else begin
            next_r_s = diff_s;
        end
        next_q_s = {q_r[N-2:0], ~borrow_s};
    end

    // FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            r_r     <= '0;
            q_r     <= '0;
            d_r     <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            quot_r  <= '0;
            rem_r   <= '0;
            dz_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            quot_r  <= '1;
                            rem_r   <= bus.dividend;
                            dz_r    <= 1'b1;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            d_r     <= bus.divisor;
                            r_r     <= '0;
                            q_r     <= bus.dividend;
                            cnt_r   <= CW'(N);
                            dz_r    <= 1'b0;
                            busy_r  <= 1'b1;
                            state_r <= CALC;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CALC: begin
                    r_r   <= next_r_s;
                    q_r   <= next_q_s;
                    cnt_r <= cnt_r - CW'(1);
                    // Last iteration: publish results straight from the step logic.
                    if (cnt_r == CW'(1)) begin
                        quot_r  <= next_q_s;
                        rem_r   <= next_r_s[N-1:0];
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quot_r;
    assign bus.remainder = rem_r;
    assign bus.div_zero  = dz_r;

endmodule
